down_count_timer: RTL and testbench

- Loadable synchronous down counter and countdown timer; the count-down counterpart to the existing 4-bit ripple up counter.
- Counts from a loaded value toward zero and flags the terminal count.
- One-shot mode stops at zero; periodic mode auto-reloads to give a fixed-period tick.
- Used as a delay or period generator beside the up counters.

---
 rtl/down_count_timer.sv | 56 +++++
 tb/tb_down_count_timer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/down_count_timer.sv
// down_count_timer: loadable down counter with one-shot and periodic terminal-count tick
module down_count_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, rld_q, rld_d;
  logic             tc_q, tc_d;
  // next state: load beats count; at q==1 mode picks stop-at-zero or reload
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;
    if (load) begin
      cnt_d   = load_val;
      rld_d   = load_val;
      state_d = (load_val != '0) ? RUN : IDLE;
    end else if (en && state_q == RUN) begin
      if (cnt_q > WIDTH'(1)) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else begin
        tc_d    = 1'b1;
        cnt_d   = mode ? rld_q : '0;
        state_d = mode ? RUN : IDLE;
      end
    end
  end
  // state registers update on the falling edge, cleared at once by reset
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rld_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
    end
  end
  assign q    = cnt_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);
endmodule

// File: tb/tb_down_count_timer.sv
// tb_down_count_timer: vector table plus scoreboard check of the down-count timer
module tb_down_count_timer;
  logic       clk = 1'b0;
  logic       reset, en, load, mode;
  logic [3:0] load_val, q;
  logic       tc, busy;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    logic       ld, en, md;
    logic [3:0] lv;
    logic [3:0] q;
    logic       tc, bz;
  } vec_t;
  typedef struct {
    logic [3:0] q;
    logic       tc, bz;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  down_count_timer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .q(q), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic v(input logic ld, input logic e, input logic md, input logic [3:0] lv,
                   input logic [3:0] eq, input logic etc, input logic ebz);
    tbl.push_back('{ld, e, md, lv, eq, etc, ebz});
  endtask

  task automatic apply(input vec_t t, input int idx);
    exp_t x;
    @(posedge clk);
    load = t.ld; en = t.en; mode = t.md; load_val = t.lv;
    sb.push_back('{t.q, t.tc, t.bz});
    @(negedge clk);
    #1;
    x = sb.pop_front();
    chk("q", idx, 32'(q), 32'(x.q));
    chk("tc", idx, 32'(tc), 32'(x.tc));
    chk("busy", idx, 32'(busy), 32'(x.bz));
  endtask

  initial begin
    vec_t t;
    reset = 1'b1; en = 1'b0; load = 1'b0; mode = 1'b0; load_val = 4'd0;
    // idle with q=0: en does nothing
    v(0,1,0,0, 0,0,0); v(0,1,1,0, 0,0,0);
    // one-shot from 4
    v(1,0,0,4, 4,0,1); v(0,1,0,0, 3,0,1); v(0,1,0,0, 2,0,1); v(0,1,0,0, 1,0,1);
    v(0,1,0,0, 0,1,0);
    for (int i = 0; i < 5; i++) v(0,1,0,0, 0,0,0);
    // periodic from 3 (en on the load edge is overridden by load)
    v(1,1,1,3, 3,0,1);
    for (int i = 0; i < 3; i++) begin
      v(0,1,1,0, 2,0,1); v(0,1,1,0, 1,0,1); v(0,1,1,0, 3,1,1);
    end
    // enable gating
    v(1,0,0,5, 5,0,1); v(0,1,0,0, 4,0,1); v(0,0,0,0, 4,0,1); v(0,0,0,0, 4,0,1);
    v(0,1,0,0, 3,0,1); v(0,1,0,0, 2,0,1);
    // load collides with the terminal-count edge, then load of zero
    v(1,0,1,2, 2,0,1); v(0,1,1,0, 1,0,1); v(1,1,1,7, 7,0,1);
    v(1,1,1,0, 0,0,0); v(0,1,1,0, 0,0,0); v(0,1,0,0, 0,0,0);
    // mode only matters on the q==1 edge
    v(1,0,1,2, 2,0,1); v(0,1,1,0, 1,0,1); v(0,1,0,0, 0,1,0);
    v(1,0,0,2, 2,0,1); v(0,1,0,0, 1,0,1); v(0,1,1,0, 2,1,1);
    // reload value 1: tc every enabled edge
    v(1,0,1,1, 1,0,1); v(0,1,1,0, 1,1,1); v(0,1,1,0, 1,1,1); v(0,1,1,0, 1,1,1);
    v(0,0,1,0, 1,0,1);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_q", 0, 32'(q), 0);
    chk("rst_tc", 0, 32'(tc), 0);
    chk("rst_busy", 0, 32'(busy), 0);
    @(posedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      t = tbl[i];
      apply(t, i);
    end

    // max load: 15 enabled edges to tc, no wrap afterwards
    apply('{1'b1, 1'b0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b1}, 100);
    for (int i = 1; i <= 15; i++)
      apply('{1'b0, 1'b1, 1'b0, 4'd0, 4'(15 - i), (i == 15), (i != 15)}, 100 + i);
    apply('{1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0}, 116);

    // asynchronous reset mid-count, then inputs ignored while held
    apply('{1'b1, 1'b0, 1'b0, 4'd9, 4'd9, 1'b0, 1'b1}, 200);
    @(posedge clk);
    load = 1'b1; load_val = 4'd6; en = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_q", 201, 32'(q), 0);
    chk("async_tc", 201, 32'(tc), 0);
    chk("async_busy", 201, 32'(busy), 0);
    @(negedge clk);
    #1;
    chk("held_q", 202, 32'(q), 0);
    chk("held_busy", 202, 32'(busy), 0);
    @(posedge clk);
    reset = 1'b0; load = 1'b0; en = 1'b0;
    apply('{1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0}, 203);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
